// File: rtl/serial_link_prbs_checker.sv
// Per-lane self-synchronising PRBS-7 (x^7+x^6+1) checker with lock tracking,
// saturating per-lane error counters and a global beat counter.
module serial_link_prbs_checker #(
    parameter int NumLanes    = 8,
    parameter int LockLen     = 16,
    parameter int LossLen     = 8,
    parameter int ErrCntWidth = 16,
    parameter int BitCntWidth = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic                            clear_i,
    input  logic                            valid_i,
    input  logic [NumLanes-1:0]             data_i,
    output logic [NumLanes-1:0]             lock_o,
    output logic [NumLanes*ErrCntWidth-1:0] err_cnt_o,
    output logic [BitCntWidth-1:0]          bit_cnt_o
);

    localparam int MatchW = $clog2(LockLen + 1);
    localparam int MissW  = $clog2(LossLen + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_ACQ,
        S_LOCKED
    } lane_state_e;

    lane_state_e             state_q [NumLanes];
    lane_state_e             state_d [NumLanes];
    logic [6:0]              hist_q  [NumLanes];
    logic [6:0]              hist_d  [NumLanes];
    logic [2:0]              fill_q  [NumLanes];
    logic [2:0]              fill_d  [NumLanes];
    logic [MatchW-1:0]       match_q [NumLanes];
    logic [MatchW-1:0]       match_d [NumLanes];
    logic [MissW-1:0]        miss_q  [NumLanes];
    logic [MissW-1:0]        miss_d  [NumLanes];
    logic [ErrCntWidth-1:0]  err_q   [NumLanes];
    logic [ErrCntWidth-1:0]  err_d   [NumLanes];
    logic [NumLanes-1:0]     lock_q;
    logic [NumLanes-1:0]     lock_d;
    logic [BitCntWidth-1:0]  bit_cnt_q;
    logic [BitCntWidth-1:0]  bit_cnt_d;
    logic                    beat;
    logic                    exp_b;

    assign beat = valid_i & en_i;

    always_comb begin
        exp_b = 1'b0;
        for (int k = 0; k < NumLanes; k++) begin
            state_d[k] = state_q[k];
            hist_d[k]  = hist_q[k];
            fill_d[k]  = fill_q[k];
            match_d[k] = match_q[k];
            miss_d[k]  = miss_q[k];
            err_d[k]   = err_q[k];
            lock_d[k]  = lock_q[k];
            exp_b      = hist_q[k][6] ^ hist_q[k][5];

            if (!en_i) begin
                state_d[k] = S_IDLE;
                hist_d[k]  = '0;
                fill_d[k]  = '0;
                match_d[k] = '0;
                miss_d[k]  = '0;
                lock_d[k]  = 1'b0;
            end else begin
                unique case (state_q[k])
                    // IDLE with a beat already counts as the first fill bit.
                    S_IDLE, S_FILL: begin
                        state_d[k] = S_FILL;
                        if (beat) begin
                            hist_d[k] = {hist_q[k][5:0], data_i[k]};
                            if (fill_q[k] == 3'd6) begin
                                fill_d[k]  = '0;
                                state_d[k] = S_ACQ;
                            end else begin
                                fill_d[k] = fill_q[k] + 3'd1;
                            end
                        end
                    end
                    S_ACQ: begin
                        if (beat) begin
                            hist_d[k] = {hist_q[k][5:0], data_i[k]};
                            if (data_i[k] == exp_b) begin
                                if (match_q[k] == MatchW'(LockLen - 1)) begin
                                    match_d[k] = '0;
                                    lock_d[k]  = 1'b1;
                                    state_d[k] = S_LOCKED;
                                end else begin
                                    match_d[k] = match_q[k] + 1'b1;
                                end
                            end else begin
                                match_d[k] = '0;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (beat) begin
                            // Free-run on the prediction so a flipped bit is one error.
                            hist_d[k] = {hist_q[k][5:0], exp_b};
                            if (data_i[k] != exp_b) begin
                                if (err_q[k] != '1) err_d[k] = err_q[k] + 1'b1;
                                if (miss_q[k] == MissW'(LossLen - 1)) begin
                                    state_d[k] = S_FILL;
                                    lock_d[k]  = 1'b0;
                                    hist_d[k]  = '0;
                                    fill_d[k]  = '0;
                                    match_d[k] = '0;
                                    miss_d[k]  = '0;
                                end else begin
                                    miss_d[k] = miss_q[k] + 1'b1;
                                end
                            end else begin
                                miss_d[k] = '0;
                            end
                        end
                    end
                    default: state_d[k] = S_IDLE;
                endcase
            end

            if (clear_i) err_d[k] = '0;
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (clear_i) begin
            bit_cnt_d = '0;
        end else if (beat && (bit_cnt_q != '1)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumLanes; k++) begin
                state_q[k] <= S_IDLE;
                hist_q[k]  <= '0;
                fill_q[k]  <= '0;
                match_q[k] <= '0;
                miss_q[k]  <= '0;
                err_q[k]   <= '0;
            end
            lock_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NumLanes; k++) begin
                state_q[k] <= state_d[k];
                hist_q[k]  <= hist_d[k];
                fill_q[k]  <= fill_d[k];
                match_q[k] <= match_d[k];
                miss_q[k]  <= miss_d[k];
                err_q[k]   <= err_d[k];
            end
            lock_q    <= lock_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign lock_o    = lock_q;
    assign bit_cnt_o = bit_cnt_q;

    for (genvar g = 0; g < NumLanes; g++) begin : g_err_pack
        assign err_cnt_o[g*ErrCntWidth +: ErrCntWidth] = err_q[g];
    end

endmodule

// File: tb/tb_serial_link_prbs_checker.sv
// Scoreboard bench: two checker instances (16-bit and 4-bit error counters)
// driven from one stimulus stream and compared against a queue-based model.
module tb_serial_link_prbs_checker;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr;
    logic         vld;
    logic [7:0]   data;
    logic [7:0]   lock16, lock4;
    logic [127:0] err16;
    logic [31:0]  err4;
    logic [31:0]  bc16, bc4;

    serial_link_prbs_checker #(.NumLanes(8), .ErrCntWidth(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vld),
        .data_i(data), .lock_o(lock16), .err_cnt_o(err16), .bit_cnt_o(bc16)
    );

    serial_link_prbs_checker #(.NumLanes(8), .ErrCntWidth(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vld),
        .data_i(data), .lock_o(lock4), .err_cnt_o(err4), .bit_cnt_o(bc4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [7:0]   lock;
        logic [127:0] e16;
        logic [31:0]  e4;
        logic [31:0]  bc;
    } exp_t;
    exp_t expq[$];

    // Reference model: received-bit window per lane plus run/miss tallies.
    bit     rx [0:7][$];
    bit     m_locked [8];
    int     m_run [8];
    int     m_miss [8];
    int     m_e16 [8];
    int     m_e4 [8];
    longint m_bc;
    bit     tx[$];

    function automatic void lane_off(int k);
        rx[k].delete();
        m_locked[k] = 1'b0;
        m_run[k]    = 0;
        m_miss[k]   = 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) begin
            lane_off(k);
            m_e16[k] = 0;
            m_e4[k]  = 0;
        end
        m_bc = 0;
    endfunction

    function automatic void lane_beat(int k, bit d);
        bit e;
        if (!m_locked[k]) begin
            if (rx[k].size() < 7) begin
                rx[k].push_back(d);
            end else begin
                e = rx[k][0] ^ rx[k][1];
                m_run[k] = (d == e) ? m_run[k] + 1 : 0;
                rx[k].push_back(d);
                void'(rx[k].pop_front());
                if (m_run[k] == 16) begin
                    m_locked[k] = 1'b1;
                    m_run[k]    = 0;
                end
            end
        end else begin
            e = rx[k][0] ^ rx[k][1];
            rx[k].push_back(e);
            void'(rx[k].pop_front());
            if (d != e) begin
                if (m_e16[k] < 65535) m_e16[k]++;
                if (m_e4[k] < 15) m_e4[k]++;
                m_miss[k]++;
                if (m_miss[k] == 8) begin
                    m_locked[k] = 1'b0;
                    m_miss[k]   = 0;
                    rx[k].delete();
                end
            end else begin
                m_miss[k] = 0;
            end
        end
    endfunction

    // PRBS-7 transmitter, seed all ones: b[n] = b[n-7] ^ b[n-6].
    function automatic bit tx_next();
        bit b;
        if (tx.size() < 7) b = 1'b1;
        else b = tx[0] ^ tx[1];
        tx.push_back(b);
        if (tx.size() > 7) void'(tx.pop_front());
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit c, input bit v, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; vld = v; data = d;
        if (!e) begin
            for (int k = 0; k < 8; k++) lane_off(k);
        end else if (v) begin
            for (int k = 0; k < 8; k++) lane_beat(k, d[k]);
        end
        if (e && v && m_bc < 64'hFFFF_FFFF) m_bc++;
        if (c) begin
            for (int k = 0; k < 8; k++) begin
                m_e16[k] = 0;
                m_e4[k]  = 0;
            end
            m_bc = 0;
        end
        x.lock = '0; x.e16 = '0; x.e4 = '0;
        for (int k = 0; k < 8; k++) begin
            x.lock[k]        = m_locked[k];
            x.e16[k*16 +: 16] = m_e16[k][15:0];
            x.e4[k*4 +: 4]    = m_e4[k][3:0];
        end
        x.bc = m_bc[31:0];
        expq.push_back(x);
    endtask

    task automatic beat_clean(input logic [7:0] flip);
        bit b;
        b = tx_next();
        step(1'b1, 1'b0, 1'b1, {8{b}} ^ flip);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                chk("lock16", lock16, x.lock);
                chk("lock4",  lock4,  x.lock);
                chk("err16",  err16,  x.e16);
                chk("err4",   err4,   x.e4);
                chk("bitcnt", bc16,   x.bc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] lane_e;
        int          r;
        logic [7:0]  flip;
        bit          b;

        rst = 1'b1; en = 1'b0; clr = 1'b0; vld = 1'b0; data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_lock", lock16, 8'h00);
        chk("rst_err16", err16, 128'h0);
        chk("rst_err4", err4, 32'h0);
        chk("rst_bitcnt", bc16, 32'd0);
        rst = 1'b0;

        // Clean acquisition on all lanes
        step(1'b1, 1'b0, 1'b0, 8'(($urandom)));
        for (int i = 1; i <= 23; i++) begin
            beat_clean(8'h00);
            if (i == 22) begin settle(); chk("acq_lock_b22", lock16, 8'h00); end
            if (i == 23) begin
                settle();
                chk("acq_lock_b23", lock16, 8'hFF);
                chk("acq_bitcnt", bc16, 32'd23);
                chk("acq_err", err16, 128'h0);
            end
        end

        // Single flipped bit on lane 3
        beat_clean(8'h08);
        settle();
        chk("flip3_err", err16, 128'h1 << 48);
        chk("flip3_lock", lock16, 8'hFF);
        repeat (3) beat_clean(8'h00);

        // Eight consecutive inverted bits on lane 0 drop lock, then reacquire
        repeat (8) beat_clean(8'h01);
        settle();
        lane_e = err16[15:0];
        chk("loss0_lock", lock16[0], 1'b0);
        chk("loss0_err", lane_e, 16'd8);
        for (int i = 1; i <= 23; i++) begin
            beat_clean(8'h00);
            if (i == 22) begin settle(); chk("relock0_b22", lock16[0], 1'b0); end
            if (i == 23) begin
                settle();
                lane_e = err16[15:0];
                chk("relock0_b23", lock16[0], 1'b1);
                chk("relock0_err", lane_e, 16'd8);
            end
        end

        // Alternate inversion on lane 1: lock holds, 4-bit counter saturates
        for (int i = 0; i < 40; i++) beat_clean((i % 2 == 0) ? 8'h02 : 8'h00);
        settle();
        lane_e = err16[31:16];
        chk("alt1_err4", err4[7:4], 4'hF);
        chk("alt1_err16", lane_e, 16'd20);
        chk("alt1_lock", lock16, 8'hFF);
        b = tx_next();
        step(1'b1, 1'b1, 1'b1, {8{b}} ^ 8'h02);
        settle();
        chk("clr_err4", err4, 32'h0);
        chk("clr_err16", err16, 128'h0);
        chk("clr_bitcnt", bc16, 32'd0);

        // Valid on alternate cycles
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 46; i++) begin
            if (i % 2 == 0) beat_clean(8'h00);
            else step(1'b1, 1'b0, 1'b0, 8'($urandom));
            if (i == 42) begin settle(); chk("gap_lock_b22", lock16, 8'h00); end
            if (i == 44) begin
                settle();
                chk("gap_lock_b23", lock16, 8'hFF);
                chk("gap_bitcnt", bc16, 32'd23);
            end
        end

        // Disable during acquisition, then reacquire from scratch
        step(1'b0, 1'b0, 1'b0, 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 8'($urandom));
        repeat (12) beat_clean(8'h00);
        repeat (3) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        settle();
        chk("endrop_lock", lock16, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 1; i <= 23; i++) begin
            beat_clean(8'h00);
            if (i == 22) begin settle(); chk("reen_lock_b22", lock16, 8'h00); end
            if (i == 23) begin settle(); chk("reen_lock_b23", lock16, 8'hFF); end
        end

        // Randomised traffic: gaps, sparse bit errors, clears, enable drops
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            flip = ($urandom_range(0, 9) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            if (r < 2) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                step(1'b1, (r < 4), 1'b0, 8'($urandom));
            end else begin
                b = tx_next();
                step(1'b1, (r < 4), 1'b1, {8{b}} ^ flip);
            end
        end

        // Lock again, then asynchronous reset between edges
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (23) beat_clean(8'h00);
        settle();
        chk("prerst_lock", lock16, 8'hFF);
        #1;
        rst = 1'b1; en = 1'b0; vld = 1'b0; clr = 1'b0;
        #1;
        chk("arst_lock", lock16, 8'h00);
        chk("arst_err16", err16, 128'h0);
        chk("arst_bitcnt", bc16, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (4) beat_clean(8'h00);

        for (int t = 0; t < 5 && expq.size() > 0; t++) @(posedge clk);
        #3;
        if (expq.size() > 0) begin
            n_mis++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
